// File: rtl/reg_arbiter_rr_pkg.sv
// Shared types for the round-robin register arbiter: default register request/response
// structs and small index/width helpers.
package reg_arbiter_rr_pkg;

    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned StrbWidth = DataWidth / 8;

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic                 write;
        logic [DataWidth-1:0] wdata;
        logic [StrbWidth-1:0] wstrb;
        logic                 valid;
    } reg_req_t;

    typedef struct packed {
        logic [DataWidth-1:0] rdata;
        logic                 error;
        logic                 ready;
    } reg_rsp_t;

    // Successor of a round-robin index; a single requester always stays at 0.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        if (idx + 32'd1 >= n) begin
            return 32'd0;
        end else begin
            return idx + 32'd1;
        end
    endfunction

    // Width of a counter that has to hold values up to max_val, never below 1 bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        if (max_val > 32'd0) begin
            return $clog2(max_val + 32'd1);
        end else begin
            return 32'd1;
        end
    endfunction

endpackage

// File: rtl/reg_arbiter_rr_select.sv
// Combinational round-robin picker: first valid requester at or after ptr, wrapping.
module reg_rr_select #(
    parameter int unsigned NumReq = 2,
    parameter int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic [NumReq-1:0] valid,
    input  logic [IdxW-1:0]   ptr,
    output logic [IdxW-1:0]   gnt_idx,
    output logic              any_valid
);

    int unsigned raw;
    int unsigned cand;
    logic        hit;

    // Scan the requesters starting at ptr; the first hit wins.
    always_comb begin
        any_valid = 1'b0;
        gnt_idx   = '0;
        raw       = 32'd0;
        cand      = 32'd0;
        hit       = 1'b0;
        for (int unsigned off = 0; off < NumReq; off++) begin
            raw       = 32'(ptr) + off;
            cand      = (raw >= NumReq) ? raw - NumReq : raw;
            hit       = !any_valid && valid[IdxW'(cand)];
            gnt_idx   = hit ? IdxW'(cand) : gnt_idx;
            any_valid = any_valid | hit;
        end
    end

endmodule

// File: rtl/reg_arbiter_rr.sv
// Round-robin arbiter sharing one register target between NumReq masters, one
// transaction in flight, with an optional per-transaction timeout error.
module reg_arbiter_rr
    import reg_arbiter_rr_pkg::*;
#(
    parameter int unsigned NumReq        = 2,
    parameter int unsigned TimeoutCycles = 0,
    parameter type         req_t         = reg_req_t,
    parameter type         rsp_t         = reg_rsp_t
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  req_t req_i [NumReq],
    output rsp_t rsp_o [NumReq],
    output req_t req_o,
    input  rsp_t rsp_i,
    output logic timeout_o
);

    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned CntW = cnt_width(TimeoutCycles);
    localparam logic [CntW-1:0] CntThr =
        CntW'((TimeoutCycles > 32'd0) ? TimeoutCycles - 32'd1 : 32'd0);
    localparam logic [CntW-1:0] CntMax = {CntW{1'b1}};

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBusy  = 2'd1,
        StDrain = 2'd2
    } state_e;

    state_e            state_q;
    req_t              req_q;
    logic [IdxW-1:0]   gnt_q;
    logic [IdxW-1:0]   rr_ptr_q;
    logic [CntW-1:0]   cnt_q;

    logic [NumReq-1:0] valid_vec;
    logic [IdxW-1:0]   sel_idx;
    logic              any_valid;
    req_t              sel_req;
    logic [IdxW-1:0]   ptr_next;
    logic              timeout_hit;

    for (genvar g = 0; g < NumReq; g++) begin : g_valid
        assign valid_vec[g] = req_i[g].valid;
    end

    reg_rr_select #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_select (
        .valid     (valid_vec),
        .ptr       (rr_ptr_q),
        .gnt_idx   (sel_idx),
        .any_valid (any_valid)
    );

    // Request captured at grant; valid is forced so a later master drop cannot stall the target.
    always_comb begin
        sel_req       = req_i[sel_idx];
        sel_req.valid = 1'b1;
    end

    assign ptr_next = IdxW'(rr_next(32'(gnt_q), NumReq));

    // A target response in the threshold cycle wins over the timeout.
    always_comb begin
        if (TimeoutCycles != 32'd0) begin
            timeout_hit = (state_q == StBusy) && (cnt_q == CntThr) && !rsp_i.ready;
        end else begin
            timeout_hit = 1'b0;
        end
    end

    assign timeout_o = timeout_hit;

    // Downstream request: held through Busy and Drain so the target handshake is never withdrawn.
    always_comb begin
        if (state_q == StIdle) begin
            req_o = '0;
        end else begin
            req_o = req_q;
        end
    end

    // Only the granted master ever sees a non-zero response, and only while Busy.
    always_comb begin
        rsp_o = '{default: '0};
        if (state_q == StBusy) begin
            if (rsp_i.ready) begin
                rsp_o[gnt_q] = rsp_i;
            end else if (timeout_hit) begin
                rsp_o[gnt_q].ready = 1'b1;
                rsp_o[gnt_q].error = 1'b1;
            end else begin
                rsp_o = '{default: '0};
            end
        end else begin
            rsp_o = '{default: '0};
        end
    end

    // Arbitration state machine with saturating Busy-cycle counter.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            req_q    <= '0;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (any_valid) begin
                        req_q   <= sel_req;
                        gnt_q   <= sel_idx;
                        state_q <= StBusy;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StBusy: begin
                    if (rsp_i.ready) begin
                        rr_ptr_q <= ptr_next;
                        state_q  <= StIdle;
                    end else if (timeout_hit) begin
                        rr_ptr_q <= ptr_next;
                        state_q  <= StDrain;
                    end else if (cnt_q != CntMax) begin
                        cnt_q <= cnt_q + CntW'(1'b1);
                    end else begin
                        cnt_q <= cnt_q;
                    end
                end
                StDrain: begin
                    // The late target response belongs to an already-answered transaction.
                    if (rsp_i.ready) begin
                        state_q <= StIdle;
                    end else begin
                        state_q <= StDrain;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_arbiter_rr.sv
// Scoreboard bench for reg_arbiter_rr: three masters, timeout of 4 cycles, a
// latency-programmable target model and a monitor that checks every master response.
module tb_reg_arbiter_rr;
    import reg_arbiter_rr_pkg::*;

    logic     clk;
    logic     rst_ni;
    reg_req_t req_i [3];
    reg_rsp_t rsp_o [3];
    reg_req_t req_o;
    reg_rsp_t rsp_i;
    logic     timeout_o;

    reg_arbiter_rr #(
        .NumReq        (3),
        .TimeoutCycles (4),
        .req_t         (reg_req_t),
        .rsp_t         (reg_rsp_t)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .req_i     (req_i),
        .rsp_o     (rsp_o),
        .req_o     (req_o),
        .rsp_i     (rsp_i),
        .timeout_o (timeout_o)
    );

    typedef struct {
        int          m;
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
        int          lat;
        int          cyc;
    } exp_t;

    exp_t        sbq [$];
    int          nvec = 0;
    int          nerr = 0;
    int          cyc = 0;
    int          tmo_pulses = 0;
    int          tgt_lat;
    int          seen;
    logic [31:0] tgt_rdata;
    logic        tgt_err;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int m, input logic [31:0] addr, input logic wr,
                           input logic [31:0] wd, input logic [3:0] ws);
        req_i[m].addr  = addr;
        req_i[m].write = wr;
        req_i[m].wdata = wd;
        req_i[m].wstrb = ws;
        req_i[m].valid = 1'b1;
    endtask

    task automatic push(input int m, input logic [31:0] addr, input logic wr,
                        input logic [31:0] wd, input logic [3:0] ws, input logic [31:0] rd,
                        input logic err, input logic tmo, input int lat);
        exp_t e;
        e.m = m; e.addr = addr; e.write = wr; e.wdata = wd; e.wstrb = ws;
        e.rdata = rd; e.err = err; e.tmo = tmo; e.lat = lat; e.cyc = cyc;
        sbq.push_back(e);
    endtask

    // Target model: answers once req_o.valid has been up for tgt_lat cycles.
    initial begin
        rsp_i = '0;
        seen  = 0;
        forever begin
            @(posedge clk);
            #2;
            if (req_o.valid) begin
                if (seen >= tgt_lat) begin
                    rsp_i.ready = 1'b1;
                    rsp_i.rdata = tgt_rdata;
                    rsp_i.error = tgt_err;
                end else begin
                    rsp_i = '0;
                end
                seen++;
            end else begin
                rsp_i = '0;
                seen  = 0;
            end
        end
    end

    int   mon_n;
    int   mon_who;
    exp_t mon_e;

    // Monitor: pops the scoreboard whenever any master sees ready.
    always @(negedge clk) begin
        mon_n   = 0;
        mon_who = -1;
        for (int i = 0; i < 3; i++) begin
            if (rsp_o[i].ready) begin
                mon_n++;
                mon_who = i;
            end else begin
                chk("rsp_quiet", 32'(|{rsp_o[i].rdata, rsp_o[i].error}), 32'd0);
            end
        end
        if (timeout_o) tmo_pulses++;
        if (mon_n > 1) chk("single_responder", 32'(mon_n), 32'd1);
        if (mon_n == 1) begin
            if (sbq.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected_rsp: master %0d got a response, none expected (cycle %0d)",
                         mon_who, cyc);
            end else begin
                mon_e = sbq.pop_front();
                chk("grant_master", 32'(mon_who), 32'(mon_e.m));
                chk("rsp_rdata", rsp_o[mon_who].rdata, mon_e.rdata);
                chk("rsp_error", 32'(rsp_o[mon_who].error), 32'(mon_e.err));
                chk("timeout_pulse", 32'(timeout_o), 32'(mon_e.tmo));
                if (mon_e.lat >= 0) chk("latency", 32'(cyc - mon_e.cyc), 32'(mon_e.lat));
                if (!mon_e.tmo) begin
                    chk("req_o_addr", req_o.addr, mon_e.addr);
                    chk("req_o_write", 32'(req_o.write), 32'(mon_e.write));
                    chk("req_o_wdata", req_o.wdata, mon_e.wdata);
                    chk("req_o_wstrb", 32'(req_o.wstrb), 32'(mon_e.wstrb));
                end
            end
        end else if (timeout_o) begin
            chk("timeout_without_rsp", 32'(mon_n), 32'd1);
        end
    end

    initial begin
        rst_ni = 1'b0;
        for (int i = 0; i < 3; i++) req_i[i] = '0;
        tgt_lat   = 0;
        tgt_rdata = 32'h0;
        tgt_err   = 1'b0;
        step(2);
        @(negedge clk);
        chk("rst_req_valid", 32'(req_o.valid), 32'd0);
        chk("rst_req_addr", req_o.addr, 32'h0);
        chk("rst_rsp_ready", 32'({rsp_o[2].ready, rsp_o[1].ready, rsp_o[0].ready}), 32'd0);
        chk("rst_timeout", 32'(timeout_o), 32'd0);
        step(1);
        rst_ni = 1'b1;
        step(1);

        // Fairness: all three masters continuously valid, zero-latency target.
        tgt_rdata = 32'h1111_2222;
        for (int k = 0; k < 3; k++) set_req(k, 32'h100 * (k + 1), 1'b0, 32'h0, 4'h0);
        for (int t = 0; t < 6; t++)
            push(t % 3, 32'h100 * ((t % 3) + 1), 1'b0, 32'h0, 4'h0, 32'h1111_2222, 1'b0, 1'b0, -1);
        step(11);
        for (int k = 0; k < 3; k++) req_i[k].valid = 1'b0;
        step(3);

        // Single access from master 0, answered in the first Busy cycle.
        tgt_rdata = 32'hDEAD_BEEF;
        set_req(0, 32'h10, 1'b0, 32'h0, 4'h0);
        push(0, 32'h10, 1'b0, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1);
        step(1);
        req_i[0].valid = 1'b0;
        step(2);

        // Write from master 1; master changes wdata while the target is still busy.
        tgt_lat   = 2;
        tgt_rdata = 32'h0;
        set_req(1, 32'h20, 1'b1, 32'h1234, 4'h3);
        push(1, 32'h20, 1'b1, 32'h1234, 4'h3, 32'h0, 1'b0, 1'b0, 3);
        step(1);
        req_i[1].wdata = 32'hFFFF_5678;
        req_i[1].wstrb = 4'hF;
        step(1);
        @(negedge clk);
        chk("wr_hold_wdata", req_o.wdata, 32'h1234);
        chk("wr_hold_wstrb", 32'(req_o.wstrb), 32'h3);
        step(1);
        req_i[1].valid = 1'b0;
        step(2);

        // Timeout: target never ready, master 2 granted; then drain a late response.
        tgt_lat = 1000000;
        set_req(2, 32'h30, 1'b0, 32'h0, 4'h0);
        push(2, 32'h30, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, 4);
        step(4);
        req_i[2].valid = 1'b0;
        step(2);
        @(negedge clk);
        chk("drain_req_valid", 32'(req_o.valid), 32'd1);
        chk("drain_req_addr", req_o.addr, 32'h30);
        step(8);
        tgt_lat = 0;
        step(1);
        @(negedge clk);
        chk("drain_exit_idle", 32'(req_o.valid), 32'd0);
        step(1);

        // Target ready exactly at the timeout threshold: normal response with its error bit.
        tgt_lat   = 3;
        tgt_err   = 1'b1;
        tgt_rdata = 32'hC0FF_EE00;
        set_req(0, 32'h40, 1'b0, 32'h0, 4'h0);
        push(0, 32'h40, 1'b0, 32'h0, 4'h0, 32'hC0FF_EE00, 1'b1, 1'b0, 4);
        step(4);
        req_i[0].valid = 1'b0;
        step(2);
        tgt_err = 1'b0;

        // Move the pointer to 2, then reset in the middle of a Busy transaction.
        tgt_lat   = 0;
        tgt_rdata = 32'h5555_0000;
        set_req(1, 32'h50, 1'b0, 32'h0, 4'h0);
        push(1, 32'h50, 1'b0, 32'h0, 4'h0, 32'h5555_0000, 1'b0, 1'b0, 1);
        step(1);
        req_i[1].valid = 1'b0;
        step(1);
        tgt_lat = 1000000;
        set_req(2, 32'h60, 1'b0, 32'h0, 4'h0);
        step(2);
        rst_ni         = 1'b0;
        req_i[2].valid = 1'b0;
        step(1);
        @(negedge clk);
        chk("rst_mid_req_valid", 32'(req_o.valid), 32'd0);
        step(1);
        rst_ni    = 1'b1;
        tgt_lat   = 0;
        tgt_rdata = 32'h6666_0000;
        set_req(1, 32'h70, 1'b0, 32'h0, 4'h0);
        set_req(2, 32'h80, 1'b0, 32'h0, 4'h0);
        push(1, 32'h70, 1'b0, 32'h0, 4'h0, 32'h6666_0000, 1'b0, 1'b0, 1);
        push(2, 32'h80, 1'b0, 32'h0, 4'h0, 32'h6666_0000, 1'b0, 1'b0, 3);
        step(1);
        req_i[1].valid = 1'b0;
        step(2);
        req_i[2].valid = 1'b0;
        step(3);

        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        chk("timeout_pulse_count", 32'(tmo_pulses), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
